// File: rtl/led_pkg.sv
// Shared types, latencies and brightness helper for the LED frame fetcher.
// Revision: 1.0
`default_nettype none

package led_pkg;

  typedef struct packed {
    logic [7:0] g;
    logic [7:0] r;
    logic [7:0] b;
  } grb_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    IMG_WAIT = 3'd2,
    PAL_WAIT = 3'd3,
    SCALE    = 3'd4
  } fetch_state_t;

  localparam int IMG_LAT   = 2;
  localparam int PAL_LAT   = 2;
  localparam int FETCH_LAT = 6;

  // (c * (level + 1)) >> 8 keeps level 255 an exact identity.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] level);
    logic [15:0] prod;
    prod = {8'h00, c} * ({8'h00, level} + 16'd1);
    return 8'(prod >> 8);
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_addr_gen.sv
// Pixel counter, frame restart, face latch and image address generation.
// Revision: 1.0 -- LED_SERPENTINE_EN selects snake-wired odd-row reversal.
`default_nettype none

module led_addr_gen #(
  parameter int WIDTH     = 32,
  parameter int HEIGHT    = 32,
  parameter int NUM_FACES = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        accept,
  input  logic                                        frame_restart,
  input  logic [$clog2(NUM_FACES)-1:0]                face_choice,
  output logic [$clog2(NUM_FACES*WIDTH*HEIGHT)-1:0]   img_addr,
  output logic                                        last_tag,
  output logic [$clog2(NUM_FACES)-1:0]                face_active
);

  localparam int PIX    = WIDTH * HEIGHT;
  localparam int IDX_W  = $clog2(PIX);
  localparam int COL_W  = $clog2(WIDTH);
  localparam int FACE_W = $clog2(NUM_FACES);

  logic [IDX_W-1:0]  count;
  logic [IDX_W-1:0]  eff_idx;
  logic [IDX_W-1:0]  phys_idx;
  logic [FACE_W-1:0] fetch_face;
  logic              restart_pending;
  logic              restart_now;
  logic              start_frame;

  // A restart seen on the same edge as a request applies to that request.
  assign restart_now = restart_pending | frame_restart;
  assign eff_idx     = restart_now ? '0 : count;
  assign start_frame = restart_now | (count == '0);
  assign fetch_face  = start_frame ? face_choice : face_active;

`ifdef LED_SERPENTINE_EN
  assign phys_idx = eff_idx[COL_W] ? {eff_idx[IDX_W-1:COL_W], ~eff_idx[COL_W-1:0]} : eff_idx;
`else
  assign phys_idx = eff_idx;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count           <= '0;
      restart_pending <= 1'b0;
      face_active     <= '0;
      img_addr        <= '0;
      last_tag        <= 1'b0;
    end else if (accept) begin
      count           <= (eff_idx == IDX_W'(PIX - 1)) ? '0 : eff_idx + IDX_W'(1);
      restart_pending <= 1'b0;
      img_addr        <= {fetch_face, phys_idx};
      last_tag        <= (eff_idx == IDX_W'(PIX - 1));
      if (start_frame) face_active <= face_choice;
    end else if (frame_restart) begin
      restart_pending <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/xilinx_single_port_ram_read_first.sv
// ============================================================================
// Module      : xilinx_single_port_ram_read_first
// Description : Single-port read-first block RAM with optional output register.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module xilinx_single_port_ram_read_first #(
    parameter int    RAM_WIDTH       = 8,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = ""
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);

    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) mem[addra] <= dina;
            ram_data <= mem[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            assign douta = ram_data;
        end else begin : g_out_reg
            logic [RAM_WIDTH-1:0] douta_reg;
            always_ff @(posedge clka) begin
                if (rsta)        douta_reg <= '0;
                else if (regcea) douta_reg <= ram_data;
            end
            assign douta = douta_reg;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/led_frame_fetcher.sv
// Multi-face palettised pixel fetcher with brightness scaling, GRB output.
// Revision: 1.0 -- optional LED_SERPENTINE_EN remaps odd rows (see led_addr_gen).
`default_nettype none

module led_frame_fetcher
  import led_pkg::*;
#(
  parameter int    WIDTH     = 32,
  parameter int    HEIGHT    = 32,
  parameter int    NUM_FACES = 8,
  parameter int    PAL_DEPTH = 256,
  parameter string IMG_FILE  = "image.mem",
  parameter string PAL_FILE  = "palette.mem"
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_req,
  input  logic                         frame_restart,
  input  logic [$clog2(NUM_FACES)-1:0] face_choice,
  input  logic [7:0]                   brightness,
  output logic                         busy,
  output logic                         grb_valid,
  output logic [23:0]                  grb_data,
  output logic                         frame_last,
  output logic [$clog2(NUM_FACES)-1:0] face_active
);

  localparam int PAL_W     = $clog2(PAL_DEPTH);
  localparam int IMG_DEPTH = NUM_FACES * WIDTH * HEIGHT;
  localparam int ADDR_W    = $clog2(IMG_DEPTH);
  localparam int WAIT_W    = $clog2(FETCH_LAT);

  fetch_state_t      state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic              accept;
  logic              last_tag;
  logic [ADDR_W-1:0] img_addr;
  logic [PAL_W-1:0]  pal_idx;
  logic [23:0]       pal_word;
  rgb_t              pal_rgb;
  grb_t              grb_scaled;

  assign accept = (state == IDLE) && pix_req;
  assign busy   = (state != IDLE);

  led_addr_gen #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_FACES(NUM_FACES)) u_addr_gen (
    .clk(clk), .rst(rst), .accept(accept), .frame_restart(frame_restart),
    .face_choice(face_choice), .img_addr(img_addr), .last_tag(last_tag),
    .face_active(face_active)
  );

  // RAMs read every cycle; addresses stay stable for the whole fetch.
  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH(PAL_W), .RAM_DEPTH(IMG_DEPTH),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(IMG_FILE)
  ) u_img_ram (
    .clka(clk), .addra(img_addr), .dina('0), .wea(1'b0), .ena(1'b1),
    .rsta(rst), .regcea(1'b1), .douta(pal_idx)
  );

  xilinx_single_port_ram_read_first #(
    .RAM_WIDTH(24), .RAM_DEPTH(PAL_DEPTH),
    .RAM_PERFORMANCE("HIGH_PERFORMANCE"), .INIT_FILE(PAL_FILE)
  ) u_pal_ram (
    .clka(clk), .addra(pal_idx), .dina('0), .wea(1'b0), .ena(1'b1),
    .rsta(rst), .regcea(1'b1), .douta(pal_word)
  );

  assign pal_rgb      = pal_word;
  assign grb_scaled.g = scale_chan(pal_rgb.g, brightness);
  assign grb_scaled.r = scale_chan(pal_rgb.r, brightness);
  assign grb_scaled.b = scale_chan(pal_rgb.b, brightness);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    case (state)
      IDLE:     if (pix_req) state_nx = ISSUE;
      ISSUE:    state_nx = IMG_WAIT;
      IMG_WAIT: if (wait_cnt == WAIT_W'(IMG_LAT - 1)) state_nx = PAL_WAIT;
                else wait_cnt_nx = wait_cnt + WAIT_W'(1);
      PAL_WAIT: if (wait_cnt == WAIT_W'(PAL_LAT - 1)) state_nx = SCALE;
                else wait_cnt_nx = wait_cnt + WAIT_W'(1);
      SCALE:    state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grb_valid  <= 1'b0;
      frame_last <= 1'b0;
      grb_data   <= 24'h0;
    end else begin
      grb_valid  <= (state == SCALE);
      frame_last <= (state == SCALE) && last_tag;
      if (state == SCALE) grb_data <= grb_scaled;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_led_frame_fetcher.sv
// Directed self-checking bench for led_frame_fetcher (32x32, 8 faces, 256-entry palette).
// Revision: 1.0
`default_nettype none

module tb_led_frame_fetcher;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_req = 1'b0;
  logic        frame_restart = 1'b0;
  logic [2:0]  face_choice = 3'd0;
  logic [7:0]  brightness = 8'd255;
  logic        busy, grb_valid, frame_last;
  logic [23:0] grb_data;
  logic [2:0]  face_active;

  int checks = 0;
  int errors = 0;

  led_frame_fetcher #(
    .WIDTH(32), .HEIGHT(32), .NUM_FACES(8), .PAL_DEPTH(256),
    .IMG_FILE(""), .PAL_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .pix_req(pix_req), .frame_restart(frame_restart),
    .face_choice(face_choice), .brightness(brightness), .busy(busy),
    .grb_valid(grb_valid), .grb_data(grb_data), .frame_last(frame_last),
    .face_active(face_active)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Image byte = {face, col[4:0]}; palette[i] = {R=i, G=~i, B=5A}.
  function automatic logic [23:0] exp_grb(input logic [7:0] b);
    return {~b, b, 8'h5A};
  endfunction

  task automatic fill_mems();
    for (int a = 0; a < 8192; a++) begin
      logic [12:0] av;
      av = a[12:0];
      dut.u_img_ram.mem[av] = {av[12:10], av[4:0]};
    end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = i[7:0];
      dut.u_pal_ram.mem[iv] = {iv, ~iv, 8'h5A};
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic fetch(input logic rs, output logic [23:0] d, output logic last, output int lat);
    pix_req = 1'b1;
    frame_restart = rs;
    @(negedge clk);
    pix_req = 1'b0;
    frame_restart = 1'b0;
    lat = 0;
    while (!grb_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    d = grb_data;
    last = frame_last;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({busy, grb_valid, frame_last} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b exp 000", {busy, grb_valid, frame_last});
    end
    checks++;
    if (grb_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h exp 000000", grb_data); end
    checks++;
    if (face_active !== 3'd0) begin errors++; $display("FAIL reset_face got %0d exp 0", face_active); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    dut.u_img_ram.mem[0] = 8'h03;
    dut.u_pal_ram.mem[3] = 24'hAA5511;
    apply_reset();
    pix_req = 1'b1;
    @(negedge clk);
    pix_req = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (busy !== 1'b1 || grb_valid !== 1'b0) begin
        errors++; $display("FAIL single_busy k=%0d got busy=%b valid=%b exp 1 0", k, busy, grb_valid);
      end
      @(negedge clk);
    end
    checks++;
    if (grb_valid !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL single_valid got valid=%b busy=%b exp 1 0", grb_valid, busy);
    end
    checks++;
    if (grb_data !== 24'h55AA11) begin errors++; $display("FAIL single_data got %h exp 55aa11", grb_data); end
    @(negedge clk);
    checks++;
    if (grb_valid !== 1'b0 || grb_data !== 24'h55AA11) begin
      errors++; $display("FAIL single_hold got valid=%b data=%h exp 0 55aa11", grb_valid, grb_data);
    end
    dut.u_img_ram.mem[0] = 8'h00;
    dut.u_pal_ram.mem[3] = {8'h03, 8'hFC, 8'h5A};
  endtask

  task automatic test_scaling();
    logic [23:0] d; logic last; int lat;
    dut.u_pal_ram.mem[0] = 24'hFF8040;
    brightness = 8'd128;
    apply_reset();
    fetch(1'b0, d, last, lat);
    checks++;
    if (lat != 6 || d !== 24'h408020) begin
      errors++; $display("FAIL scale_128 got %h lat %0d exp 408020 lat 6", d, lat);
    end
    brightness = 8'd0;
    apply_reset();
    fetch(1'b0, d, last, lat);
    checks++;
    if (lat != 6 || d !== 24'h000000) begin
      errors++; $display("FAIL scale_0 got %h lat %0d exp 000000 lat 6", d, lat);
    end
    brightness = 8'd255;
    dut.u_pal_ram.mem[0] = {8'h00, 8'hFF, 8'h5A};
  endtask

  task automatic test_busy_ignore();
    logic [23:0] d; logic last; int lat; int nv;
    apply_reset();
    pix_req = 1'b1; @(negedge clk);
    pix_req = 1'b0; @(negedge clk);
    pix_req = 1'b1; @(negedge clk);
    pix_req = 1'b0; @(negedge clk);
    pix_req = 1'b1; @(negedge clk);
    pix_req = 1'b0;
    nv = 0;
    for (int k = 0; k < 16; k++) begin
      if (grb_valid) nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 1) begin errors++; $display("FAIL busy_ignore valids got %0d exp 1", nv); end
    fetch(1'b0, d, last, lat);
    checks++;
    if (lat != 6 || d !== exp_grb(8'h01)) begin
      errors++; $display("FAIL busy_next got %h lat %0d exp %h lat 6", d, lat, exp_grb(8'h01));
    end
  endtask

  task automatic test_wrap_face();
    logic [23:0] d; logic last; int lat;
    logic [9:0] pv;
    apply_reset();
    face_choice = 3'd0;
    for (int p = 0; p < 1024; p++) begin
      if (p == 500) face_choice = 3'd5;
      pv = p[9:0];
      fetch(1'b0, d, last, lat);
      checks++;
      if (lat != 6 || d !== exp_grb({3'd0, pv[4:0]})) begin
        errors++; $display("FAIL wrap_data p=%0d got %h lat %0d exp %h", p, d, lat, exp_grb({3'd0, pv[4:0]}));
      end
      checks++;
      if (last !== (p == 1023)) begin
        errors++; $display("FAIL wrap_last p=%0d got %b exp %b", p, last, (p == 1023));
      end
    end
    checks++;
    if (face_active !== 3'd0) begin errors++; $display("FAIL wrap_face_hold got %0d exp 0", face_active); end
    fetch(1'b0, d, last, lat);
    checks++;
    if (d !== exp_grb({3'd5, 5'd0}) || last !== 1'b0) begin
      errors++; $display("FAIL wrap_next_frame got %h last %b exp %h last 0", d, last, exp_grb({3'd5, 5'd0}));
    end
    checks++;
    if (face_active !== 3'd5) begin errors++; $display("FAIL wrap_face_new got %0d exp 5", face_active); end
  endtask

  task automatic test_restart();
    logic [23:0] d; logic last; int lat;
    apply_reset();
    face_choice = 3'd1;
    for (int p = 0; p < 37; p++) fetch(1'b0, d, last, lat);
    checks++;
    if (d !== exp_grb({3'd1, 5'd4})) begin
      errors++; $display("FAIL restart_p36 got %h exp %h", d, exp_grb({3'd1, 5'd4}));
    end
    frame_restart = 1'b1;
    face_choice = 3'd2;
    @(negedge clk);
    frame_restart = 1'b0;
    @(negedge clk);
    fetch(1'b0, d, last, lat);
    checks++;
    if (d !== exp_grb({3'd2, 5'd0}) || face_active !== 3'd2) begin
      errors++; $display("FAIL restart_pending got %h face %0d exp %h face 2", d, face_active, exp_grb({3'd2, 5'd0}));
    end
    fetch(1'b0, d, last, lat);
    checks++;
    if (d !== exp_grb({3'd2, 5'd1})) begin
      errors++; $display("FAIL restart_after got %h exp %h", d, exp_grb({3'd2, 5'd1}));
    end
    face_choice = 3'd3;
    fetch(1'b1, d, last, lat);
    checks++;
    if (d !== exp_grb({3'd3, 5'd0}) || face_active !== 3'd3) begin
      errors++; $display("FAIL restart_same_edge got %h face %0d exp %h face 3", d, face_active, exp_grb({3'd3, 5'd0}));
    end
  endtask

  task automatic test_reset_midfetch();
    logic [23:0] d; logic last; int lat; int nv;
    apply_reset();
    face_choice = 3'd3;
    fetch(1'b0, d, last, lat);
    pix_req = 1'b1; @(negedge clk);
    pix_req = 1'b0; @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, grb_valid, frame_last} !== 3'b000 || grb_data !== 24'h0 || face_active !== 3'd0) begin
      errors++; $display("FAIL midfetch_reset got busy=%b valid=%b last=%b data=%h face=%0d exp all 0",
                         busy, grb_valid, frame_last, grb_data, face_active);
    end
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    for (int k = 0; k < 12; k++) begin
      if (grb_valid) nv++;
      @(negedge clk);
    end
    checks++;
    if (nv != 0) begin errors++; $display("FAIL midfetch_ghost valids got %0d exp 0", nv); end
    face_choice = 3'd4;
    fetch(1'b0, d, last, lat);
    checks++;
    if (lat != 6 || d !== exp_grb({3'd4, 5'd0})) begin
      errors++; $display("FAIL midfetch_restart got %h lat %0d exp %h", d, lat, exp_grb({3'd4, 5'd0}));
    end
  endtask

`ifdef LED_SERPENTINE_EN
  task automatic test_serpentine();
    logic [23:0] d; logic last; int lat;
    apply_reset();
    face_choice = 3'd0;
    for (int p = 0; p < 33; p++) fetch(1'b0, d, last, lat);
    checks++;
    if (d !== exp_grb(8'h1F)) begin errors++; $display("FAIL serp_p32 got %h exp %h", d, exp_grb(8'h1F)); end
    fetch(1'b0, d, last, lat);
    checks++;
    if (d !== exp_grb(8'h1E)) begin errors++; $display("FAIL serp_p33 got %h exp %h", d, exp_grb(8'h1E)); end
  endtask
`endif

  initial begin
    fill_mems();
    test_reset();
    test_single();
    test_scaling();
    test_busy_ignore();
    test_wrap_face();
    test_restart();
    test_reset_midfetch();
`ifdef LED_SERPENTINE_EN
    test_serpentine();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_frame_fetcher.md
Name: led_frame_fetcher

Overview:
- Parametrised successor to the single-face LED image source.
- Fetches one pixel per request from a multi-face palettised image RAM and resolves it through a palette RAM.
- Applies global brightness scaling and presents GRB data to the WS2812-style LED driver through a request/valid handshake.
- Face selection is frame-synchronous; a new face takes effect only at pixel 0. Optional serpentine address remap for snake-wired panels.

Parameters:
- WIDTH, 32, panel columns
- HEIGHT, 32, panel rows
- NUM_FACES, 8, number of images stored back-to-back in the image RAM (power of 2, ≥2)
- PAL_DEPTH, 256, palette entries; index width clog2(PAL_DEPTH)
- IMG_FILE, "image.mem", image RAM init file
- PAL_FILE, "palette.mem", palette RAM init file

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, asynchronous, active-high
- pix_req  in  1  driver requests next pixel; sampled only in IDLE
- frame_restart  in  1  pulse; next accepted request fetches pixel 0
- face_choice  in  clog2(NUM_FACES)  requested face
- brightness  in  8  global scale, 255 = full
- busy  out  1  fetch in flight (FSM not IDLE)
- grb_valid  out  1  one-cycle pulse, grb_data is new
- grb_data  out  24  {G,R,B}, held between valids
- frame_last  out  1  coincident with grb_valid for pixel WIDTH*HEIGHT-1
- face_active  out  clog2(NUM_FACES)  face latched for the current frame

Behaviour:
- Reset (async assert, sync release):
  - FSM to IDLE, pixel counter 0, face_active 0.
  - busy, grb_valid and frame_last 0; grb_data 24'h0.
  - restart_pending cleared. In-flight fetches are discarded; no valid is produced after reset.
- FSM states and transitions:
  - IDLE: pix_req=1 → ISSUE.
  - ISSUE: drive image address → IMG_WAIT.
  - IMG_WAIT: 2 cycles (HIGH_PERFORMANCE RAM) → PAL_WAIT.
  - PAL_WAIT: 2 cycles → SCALE.
  - SCALE: 1 cycle → IDLE, pulsing grb_valid.
- Latency: pix_req sampled at edge N ⇒ grb_valid high for cycle after edge N+6.
  - busy is high from edge N+1 through edge N+6.
  - pix_req while busy is ignored (not queued).
  - A pix_req sampled in the IDLE cycle right after valid is accepted, giving 7-cycle throughput.
- Image address = face_active*(WIDTH*HEIGHT) + phys_idx.
  - Width is clog2(NUM_FACES*WIDTH*HEIGHT); the concatenation form is required, not a case table.
- Pixel counter:
  - Increments on each accepted request.
  - Wraps WIDTH*HEIGHT-1 → 0; frame_last accompanies the wrap pixel's valid.
- Face latch: when an accepted request has counter==0, face_active ← face_choice. A face_choice change mid-frame has no effect until the next frame.
- frame_restart:
  - Sets restart_pending, which forces counter to 0 (and re-latches the face) at the next accepted request, then clears.
  - Restart and request on the same edge: restart applies to that request.
- Scaling: each channel out = (c*(brightness+1))>>8.
  - 16-bit intermediate, no rounding.
  - brightness=255 is identity; brightness=0 gives 0.
- GRB reorder: palette stores {R,G,B}; grb_data = {G,R,B}.

Optional Feature:
- Macro LED_SERPENTINE_EN.
- Defined: phys_idx remaps odd rows right-to-left: row=idx/WIDTH, col=idx%WIDTH, phys = row*WIDTH + (row odd ? WIDTH-1-col : col).
  - Computed combinationally from the counter; latency is unchanged.
- Undefined: phys_idx = counter (raster order).

Decomposition:
- Package led_pkg holds:
  - typedef grb_t (packed struct g,r,b of 8 bits) and rgb_t.
  - FSM state enum fetch_state_t.
  - localparams IMG_LAT=2, PAL_LAT=2, FETCH_LAT=6.
- Sub-module led_addr_gen: pixel counter, wrap, restart_pending, face latch, serpentine remap.
  - Outputs image address, frame_last tag and face_active.
- RAMs use the existing xilinx_single_port_ram_read_first instances.

Test Plan:
- Reset then single req at edge 10, with image[0]=8'h03 and palette[3]=24'hAA5511, brightness=255 → grb_valid at edge 16, grb_data=24'h55AA11, busy high for edges 11–16.
- 1024 back-to-back reqs → counter wraps; frame_last only on the 1024th valid; the 1025th fetch reads address 0.
- face_choice changed 0→5 at pixel 500 → pixels 500–1023 still from face 0; pixel 0 of the next frame reads address 5120 and face_active=5.
- brightness=128 with palette 24'hFF8040 → grb_data=24'h408020; brightness=0 → 24'h000000.
- req pulses at N+2 and N+4 while busy → exactly one valid; frame_restart at pixel 37 → next fetch is address face*1024+0.
- rst asserted at edge N+3 mid-fetch → all outputs 0 immediately, no valid follows. With LED_SERPENTINE_EN, pixel 32 fetches phys 63.
